pc_unit: RTL and testbench

//   Program-counter register of the pipelined CPU. Drives pc_out into the
//   PC+1 incrementer and takes the incremented value back as the sequential

---
 rtl/pc_unit.sv | 114 +++++++++++
 tb/tb_pc_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
//   Program-counter register for the pipelined CPU. Chooses the next PC from
//   the sequential incrementer, a decoded jump or a resolved branch. It holds
//   the PC on pipeline stalls, stops permanently on HALT until reset, and
//   supports debug single-stepping. It also counts every PC write for the
//   debug unit.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous, active-high reset
//   pc_seq        in   pc_out + 1 from the external incrementer
//   jump          in   jump decoded in ID
//   jump_target   in   jump destination
//   branch_taken  in   branch resolved taken in EX
//   branch_target in   branch destination
//   stall         in   hazard unit freezes fetch
//   halt          in   HALT instruction decoded
//   debug_mode    in   1 = advance only on debug_step
//   debug_step    in   single-cycle step request
//   pc_out        out  current PC
//   pc_updated    out  1-cycle pulse after each PC write
//   halted        out  1 while in HALTED
//   update_count  out  PC writes since reset (wraps)
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int                   BUS_WIDTH = 32,
  parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0,
  parameter int                   CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] pc_seq,
  input  logic                 jump,
  input  logic [BUS_WIDTH-1:0] jump_target,
  input  logic                 branch_taken,
  input  logic [BUS_WIDTH-1:0] branch_target,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 debug_mode,
  input  logic                 debug_step,
  output logic [BUS_WIDTH-1:0] pc_out,
  output logic                 pc_updated,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] update_count
);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_STEP_WAIT = 2'd1;
  localparam logic [1:0] ST_HALTED    = 2'd2;

  logic [1:0]           state_reg, state_next;
  logic [BUS_WIDTH-1:0] pc_reg, pc_next;
  logic                 pc_updated_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic                 write_next;
  logic                 advance;

  // In RUN, the PC moves every cycle unless the debugger has taken over.
  // In STEP_WAIT, the PC moves only on a step request. A step that meets a
  // stall is consumed without moving the PC; it is not queued.
  assign advance = ((state_reg == ST_RUN) && !debug_mode) ||
                   ((state_reg == ST_STEP_WAIT) && debug_step);

  always_comb begin
    pc_next    = pc_reg;
    state_next = state_reg;
    write_next = 1'b0;

    case (state_reg)
      ST_RUN:       if (debug_mode)  state_next = ST_STEP_WAIT;
      ST_STEP_WAIT: if (!debug_mode) state_next = ST_RUN;
      default:      state_next = ST_HALTED;   // HALTED is sticky
    endcase

    if (advance) begin
      if (branch_taken) begin
        // The branch belongs to an older instruction. It overrides a stall
        // and squashes a younger HALT.
        pc_next    = branch_target;
        write_next = 1'b1;
      end else if (halt) begin
        // HALT suppresses the write that would otherwise happen this cycle.
        state_next = ST_HALTED;
      end else if (jump && !stall) begin
        pc_next    = jump_target;
        write_next = 1'b1;
      end else if (!stall) begin
        pc_next    = pc_seq;
        write_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_RUN;
      pc_reg         <= RESET_PC;
      pc_updated_reg <= 1'b0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      pc_updated_reg <= write_next;
      count_reg      <= count_reg + CNT_WIDTH'(write_next);
    end
  end

  assign pc_out       = pc_reg;
  assign pc_updated   = pc_updated_reg;
  assign halted       = (state_reg == ST_HALTED);
  assign update_count = count_reg;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_seq;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall, halt, debug_mode, debug_step;
  logic [31:0] pc_out;
  logic        pc_updated, halted;
  logic [31:0] update_count;

  // Narrow instance used to exercise PC wrap, counter wrap and a non-zero RESET_PC.
  logic        rst2;
  logic [7:0]  pc_seq2, pc_out2;
  logic        pc_updated2, halted2;
  logic [1:0]  update_count2;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // This models the external incrementer, which is not part of the DUT.
  assign pc_seq  = pc_out + 32'd1;
  assign pc_seq2 = pc_out2 + 8'd1;

  pc_unit dut (
    .clk(clk), .rst(rst), .pc_seq(pc_seq), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
    .halt(halt), .debug_mode(debug_mode), .debug_step(debug_step),
    .pc_out(pc_out), .pc_updated(pc_updated), .halted(halted),
    .update_count(update_count)
  );

  pc_unit #(.BUS_WIDTH(8), .RESET_PC(8'hFE), .CNT_WIDTH(2)) dut_narrow (
    .clk(clk), .rst(rst2), .pc_seq(pc_seq2), .jump(1'b0), .jump_target(8'h00),
    .branch_taken(1'b0), .branch_target(8'h00), .stall(1'b0),
    .halt(1'b0), .debug_mode(1'b0), .debug_step(1'b0),
    .pc_out(pc_out2), .pc_updated(pc_updated2), .halted(halted2),
    .update_count(update_count2)
  );

  typedef struct {
    logic        jump;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic        stall;
    logic        halt;
    logic        dm;
    logic        ds;
    logic [31:0] e_pc;
    logic        e_upd;
    logic        e_halt;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests_run++;
    if (act !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic drive_idle();
    jump = 0; jump_target = 0; branch_taken = 0; branch_target = 0;
    stall = 0; halt = 0; debug_mode = 0; debug_step = 0;
  endtask

  initial begin
    int upd_cnt;
    // jump jt br bt stall halt dm ds | pc upd halted cnt
    vecs[0]  = '{0, 0,     0, 0,      0, 0, 0, 0,  32'h1,   1, 0, 1};
    vecs[1]  = '{0, 0,     0, 0,      0, 0, 0, 0,  32'h2,   1, 0, 2};
    vecs[2]  = '{0, 0,     0, 0,      0, 0, 0, 0,  32'h3,   1, 0, 3};
    vecs[3]  = '{0, 0,     0, 0,      0, 0, 0, 0,  32'h4,   1, 0, 4};
    vecs[4]  = '{0, 0,     0, 0,      0, 0, 0, 0,  32'h5,   1, 0, 5};
    vecs[5]  = '{0, 0,     0, 0,      1, 0, 0, 0,  32'h5,   0, 0, 5};
    vecs[6]  = '{0, 0,     0, 0,      1, 0, 0, 0,  32'h5,   0, 0, 5};
    vecs[7]  = '{0, 0,     1, 32'h40, 1, 0, 0, 0,  32'h40,  1, 0, 6};
    vecs[8]  = '{1, 32'h20,1, 32'h80, 0, 0, 0, 0,  32'h80,  1, 0, 7};
    vecs[9]  = '{1, 32'h20,0, 0,      0, 0, 0, 0,  32'h20,  1, 0, 8};
    vecs[10] = '{1, 32'h30,0, 0,      1, 0, 0, 0,  32'h20,  0, 0, 8};
    vecs[11] = '{0, 0,     1, 32'h100,0, 1, 0, 0,  32'h100, 1, 0, 9};
    vecs[12] = '{0, 0,     0, 0,      0, 0, 0, 0,  32'h101, 1, 0, 10};
    vecs[13] = '{0, 0,     0, 0,      0, 0, 1, 0,  32'h101, 0, 0, 10};
    vecs[14] = '{0, 0,     0, 0,      0, 0, 1, 0,  32'h101, 0, 0, 10};
    vecs[15] = '{0, 0,     0, 0,      0, 0, 1, 1,  32'h102, 1, 0, 11};
    vecs[16] = '{0, 0,     0, 0,      1, 0, 1, 1,  32'h102, 0, 0, 11};
    vecs[17] = '{0, 0,     0, 0,      0, 0, 1, 1,  32'h103, 1, 0, 12};
    vecs[18] = '{0, 0,     0, 0,      0, 0, 1, 1,  32'h104, 1, 0, 13};
    vecs[19] = '{0, 0,     0, 0,      0, 0, 1, 0,  32'h104, 0, 0, 13};
    vecs[20] = '{0, 0,     0, 0,      0, 0, 0, 0,  32'h104, 0, 0, 13};
    vecs[21] = '{0, 0,     0, 0,      0, 0, 0, 0,  32'h105, 1, 0, 14};
    vecs[22] = '{1, 32'h7, 0, 0,      0, 0, 0, 0,  32'h7,   1, 0, 15};
    vecs[23] = '{0, 0,     0, 0,      0, 1, 0, 0,  32'h7,   0, 1, 15};
    vecs[24] = '{0, 0,     0, 0,      0, 0, 0, 0,  32'h7,   0, 1, 15};
    vecs[25] = '{0, 0,     1, 32'h55, 0, 0, 0, 0,  32'h7,   0, 1, 15};

    drive_idle();
    rst = 1; rst2 = 1;
    @(negedge clk);
    check("reset_pc", pc_out, 32'h0);
    check("reset_upd", {31'b0, pc_updated}, 32'h0);
    check("reset_halted", {31'b0, halted}, 32'h0);
    check("reset_cnt", update_count, 32'h0);
    rst = 0;

    // Table-driven vectors: apply at negedge, check at the following negedge.
    for (int i = 0; i < NV; i++) begin
      jump = vecs[i].jump; jump_target = vecs[i].jt;
      branch_taken = vecs[i].br; branch_target = vecs[i].bt;
      stall = vecs[i].stall; halt = vecs[i].halt;
      debug_mode = vecs[i].dm; debug_step = vecs[i].ds;
      @(negedge clk);
      $display("[TB] vec %0d: pc=0x%0h upd=%0b halted=%0b cnt=%0d", i, pc_out, pc_updated, halted, update_count);
      check($sformatf("vec%0d_pc", i), pc_out, vecs[i].e_pc);
      check($sformatf("vec%0d_upd", i), {31'b0, pc_updated}, {31'b0, vecs[i].e_upd});
      check($sformatf("vec%0d_halted", i), {31'b0, halted}, {31'b0, vecs[i].e_halt});
      check($sformatf("vec%0d_cnt", i), update_count, vecs[i].e_cnt);
    end

    // HALTED is sticky: the PC holds at 7 for 10 cycles with normal inputs.
    drive_idle();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      $display("[TB] halted cycle %0d: pc=0x%0h halted=%0b", c, pc_out, halted);
      check("halt_hold_pc", pc_out, 32'h7);
      check("halt_hold_flag", {31'b0, halted}, 32'h1);
    end

    // Asynchronous reset applied between clock edges.
    #2 rst = 1;
    #1;
    $display("[TB] async rst: pc=0x%0h halted=%0b cnt=%0d", pc_out, halted, update_count);
    check("async_rst_pc", pc_out, 32'h0);
    check("async_rst_halted", {31'b0, halted}, 32'h0);
    check("async_rst_cnt", update_count, 32'h0);
    @(negedge clk);
    rst = 0;

    // Debug mode: steps at cycles 3 and 7 must advance the PC exactly twice.
    debug_mode = 1;
    upd_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      debug_step = (c == 3 || c == 7);
      @(negedge clk);
      if (pc_updated) upd_cnt++;
      $display("[TB] debug cycle %0d: step=%0b pc=0x%0h upd=%0b", c, debug_step, pc_out, pc_updated);
    end
    check("debug_updates", upd_cnt, 2);
    check("debug_pc", pc_out, 32'h2);
    check("debug_cnt", update_count, 32'h2);

    // Reset while a step is pending must return the FSM to RUN.
    debug_step = 1;
    #2 rst = 1;
    #1 check("midstep_rst_pc", pc_out, 32'h0);
    @(negedge clk);
    debug_mode = 0; debug_step = 0;
    rst = 0;
    @(negedge clk);
    $display("[TB] after midstep rst: pc=0x%0h upd=%0b", pc_out, pc_updated);
    check("midstep_run_pc", pc_out, 32'h1);
    check("midstep_run_upd", {31'b0, pc_updated}, 32'h1);

    // Narrow instance: the PC wraps from 0xFF to 0x00 and the 2-bit counter wraps.
    check("narrow_reset_pc", {24'b0, pc_out2}, 32'hFE);
    rst2 = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      $display("[TB] narrow %0d: pc=0x%0h cnt=%0d", k, pc_out2, update_count2);
      check("narrow_pc", {24'b0, pc_out2}, {24'b0, 8'(8'hFE + k)});
      check("narrow_cnt", {30'b0, update_count2}, {30'b0, 2'(k)});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
